// File: rtl/gpio_clk_gen_if.sv
// ---------------------------------------------------------------------------
// gpio_clk_gen_if
// Avalon-MM slave bus bundle for gpio_clk_gen.
//   address     3-bit word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    32-bit read data (combinational, zero wait states)
// Modports: master (interconnect / bench side), slave (gpio_clk_gen side).
// ---------------------------------------------------------------------------
interface gpio_clk_gen_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/gpio_clk_gen.sv
// ---------------------------------------------------------------------------
// gpio_clk_gen
// Avalon-MM slave output port with WIDTH channels. Each channel drives either
// a static level (DATA bit) or a free-running 50%-duty divided clock whose
// half-period is (DIV+1) system cycles.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   bus       gpio_clk_gen_if.slave (address/chipselect/write_n/writedata/readdata)
//   out_port  registered channel outputs
//
// Register map (word addresses):
//   0 DATA  R/W   1 MODE R/W   2 SET W   3 CLEAR W
//   4 CHSEL R/W   5 DIV  R/W (channel CHSEL)   6 OUT R   7 SYNC W
//
// Optional feature: define GPIO_CLK_GEN_SYNC_EN to enable the SYNC register
// (address 7), which restarts the selected channels' dividers on one edge.
// Without the macro address 7 reads 0 and writes are ignored.
//
// Bus handshake: there is no waitrequest. A write is accepted on every rising
// edge where chipselect=1 and write_n=0; readdata is valid in the same cycle
// the address is presented. Reads have no side effects.
// ---------------------------------------------------------------------------
module gpio_clk_gen #(
  parameter int               WIDTH     = 8,
  parameter int               DIV_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [DIV_W-1:0] DIV_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  gpio_clk_gen_if.slave     bus,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_MODE  = 3'd1;
  localparam logic [2:0] ADDR_SET   = 3'd2;
  localparam logic [2:0] ADDR_CLEAR = 3'd3;
  localparam logic [2:0] ADDR_CHSEL = 3'd4;
  localparam logic [2:0] ADDR_DIV   = 3'd5;
  localparam logic [2:0] ADDR_OUT   = 3'd6;
`ifdef GPIO_CLK_GEN_SYNC_EN
  localparam logic [2:0] ADDR_SYNC  = 3'd7;
`endif

  logic [WIDTH-1:0]            data_q,  data_d;
  logic [WIDTH-1:0]            mode_q,  mode_d;
  logic [4:0]                  chsel_q, chsel_d;
  logic [WIDTH-1:0][DIV_W-1:0] div_q,   div_d;
  logic [WIDTH-1:0][DIV_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0]            phase_q, phase_d;
  logic [WIDTH-1:0]            out_q,   out_d;

  logic             wr;
  logic [WIDTH-1:0] wd_ch;
  logic [WIDTH-1:0] restart;
  logic [31:0]      rd;

  // Upper writedata bits beyond WIDTH/DIV_W are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // Register writes and per-channel restart requests.
  always_comb begin
    wr      = bus.chipselect & ~bus.write_n;
    wd_ch   = bus.writedata[WIDTH-1:0];
    data_d  = data_q;
    mode_d  = mode_q;
    chsel_d = chsel_q;
    div_d   = div_q;
    restart = '0;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:  data_d = wd_ch;
        ADDR_MODE: begin
          mode_d  = wd_ch;
          // Only a 0->1 transition restarts the divider; rewriting 1 keeps it running.
          restart = wd_ch & ~mode_q;
        end
        ADDR_SET:   data_d = data_q | wd_ch;
        ADDR_CLEAR: data_d = data_q & ~wd_ch;
        ADDR_CHSEL: chsel_d = bus.writedata[4:0];
        ADDR_DIV: begin
          // CHSEL values at or above WIDTH match no channel, so the write drops.
          for (int i = 0; i < WIDTH; i++) begin
            if (chsel_q == 5'(i)) begin
              div_d[i]   = bus.writedata[DIV_W-1:0];
              restart[i] = 1'b1;
            end
          end
        end
`ifdef GPIO_CLK_GEN_SYNC_EN
        ADDR_SYNC:  restart = wd_ch;
`endif
        default: ;
      endcase
    end
  end

  // Per-channel divider. A restart takes priority over a terminal-count wrap.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (restart[i]) begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end else if (mode_q[i]) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i]   = '0;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
    end
    // Uses pre-edge MODE/DATA/phase, giving one edge of latency after a write.
    out_d = (mode_q & phase_q) | (~mode_q & data_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_VAL;
      mode_q  <= '0;
      chsel_q <= '0;
      div_q   <= {WIDTH{DIV_RESET}};
      cnt_q   <= '0;
      phase_q <= '0;
      out_q   <= '0;
    end else begin
      data_q  <= data_d;
      mode_q  <= mode_d;
      chsel_q <= chsel_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  // Combinational read mux; unused bits and write-only registers read 0.
  always_comb begin
    rd = '0;
    case (bus.address)
      ADDR_DATA:  rd[WIDTH-1:0] = data_q;
      ADDR_MODE:  rd[WIDTH-1:0] = mode_q;
      ADDR_CHSEL: rd[4:0]       = chsel_q;
      ADDR_DIV: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (chsel_q == 5'(i)) rd[DIV_W-1:0] = div_q[i];
        end
      end
      ADDR_OUT:   rd[WIDTH-1:0] = out_q;
      default:    rd = '0;
    endcase
  end

  assign bus.readdata = rd;
  assign out_port     = out_q;

endmodule
